isq_enq_stage: RTL and testbench
================================

# isq_enq_stage

Two-entry staging buffer sitting between dispatch and the issue-queue age buffer: it is the producer side of the age buffer's enqueue handshake. It registers dispatched instructions and presents them in order on `enq_*`. While entries wait, it snoops the writeback condition-update broadcast so no wakeup is lost between dispatch and queue entry. It also kills staged entries younger than a flush point.

## Interface
Parameters:
- `DATA_WIDTH`, 248: packed dispatch word; ROB id occupies bits [247:241].
- `CONDITION_WIDTH`, 2: per-instruction condition (operand-ready) bits.
- `INDEX_WIDTH`, 4: opaque index carried alongside the data.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clock` in 1: sole clock.
  - `reset_n` in 1: asynchronous, active-low reset.
- Dispatch side:
  - `disp_valid` in 1: dispatch offers an instruction.
  - `disp_ready` out 1: stage can accept.
  - `disp_data` in DATA_WIDTH.
  - `disp_condition` in CONDITION_WIDTH.
  - `disp_index` in INDEX_WIDTH.
- Age-buffer side:
  - `enq_valid` out 1: head entry offered.
  - `enq_ready` in 1: age buffer has a free slot.
  - `enq_data` out DATA_WIDTH.
  - `enq_condition` out CONDITION_WIDTH.
  - `enq_index` out INDEX_WIDTH.
- Condition broadcast:
  - `update_condition_valid` in 1.
  - `update_condition_robid` in `ROB_SIZE_LOG+1`.
  - `update_condition_mask` in CONDITION_WIDTH.
  - `update_condition_in` in CONDITION_WIDTH.
- Flush:
  - `flush_valid` in 1.
  - `flush_robid` in `ROB_SIZE_LOG+1`.
- Status:
  - `occupancy` out 2: number of valid staged entries, 0..2.

## Operation
- Storage: 2-entry circular FIFO; 1-bit head and tail pointers; 2-bit count.
- Dispatch accept:
  - `disp_ready = (count < 2) & !flush_valid`, derived from registers and `flush_valid` only; it is independent of `enq_ready`.
  - Accept = `disp_valid & disp_ready`; the accepted instruction is written at tail.
- Enqueue:
  - `enq_valid = head_valid & !head_kill`.
  - `enq_data` and `enq_index` come from the head entry.
  - Handshake = `enq_valid & enq_ready`; the head is then popped.
- Condition update: an entry matches when `update_condition_valid` is set and `update_condition_robid` equals the entry's bits [247:241].
  - A matching entry stores `cond = (cond & ~mask) | (in & mask)`.
  - The update also applies to an instruction being accepted in the same cycle; it is matched against `disp_data[247:241]`.
  - `enq_condition` is the head condition with the same-cycle update merged in combinationally, so the value handed over is never stale.
- Flush: an entry is killed when its robid is strictly younger than `flush_robid`.
  - Younger iff `flush_robid[MSB] ^ rob[MSB] ^ (flush_robid[MSB-1:0] < rob[MSB-1:0])`.
  - An equal robid is kept.
  - `head_kill` / `tail_kill` are computed combinationally while `flush_valid` is high.
  - Killed entries are invalidated at the clock edge.
  - If the head is killed and the second entry survives, the survivor becomes head. Because of program order this cannot legally occur; it must still be handled without corruption.
- Simultaneous accept and enqueue at count 1: count stays at 1 and both pointers advance.
- Simultaneous flush and enqueue of a surviving head: the enqueue completes normally.

## Timing
- Latency: disp accept at cycle N → `enq_valid` at N+1 at the earliest.
- Throughput: 1 instruction per cycle sustained while `enq_ready` stays high.
- Backpressure: when `enq_ready` is low, the stage fills; `disp_ready` drops at count 2, in the cycle after the second accept.
- `enq_*` payload is held stable while `enq_valid & !enq_ready`, except for `enq_condition` merging broadcast updates.
- Reset values:
  - count, pointers and entry valids = 0.
  - `enq_valid = 0`, `occupancy = 0`.
  - `disp_ready = 1`, unless `flush_valid`.
  - Entry data and condition = 0.
- Reset asserted mid-operation: all staged entries are discarded immediately and asynchronously.

## Structure
- Shared ISQ package:
  - `ROBID_MSB = 247`, `ROBID_LSB = 241`.
  - `rob_is_younger(a, b)` function, reused by the age buffer flush logic.
  - `ROB_SIZE_LOG` width macro usage.
- Sub-module `isq_stage_entry`: one storage entry holding valid, data, condition and index.
  - It contains the robid-match condition update and the kill input.
  - Instantiated twice.
- Top level holds the pointers, count, handshakes and output muxing.

## Test plan
- Reset, then dispatch robids 0x05, 0x06, 0x07 back-to-back with `enq_ready = 1` → `enq_valid` in cycles 1-3 carrying 0x05, 0x06, 0x07 in order; `occupancy` ≤ 1.
- Hold `enq_ready = 0` and dispatch 3 instructions → the first two are accepted, `disp_ready = 0` once `occupancy = 2`, the third is held. Release `enq_ready` → order 1, 2, 3 is preserved.
- Stage robid 0x0A with condition 2'b00, then broadcast robid 0x0A, mask 2'b01, in 2'b01 → `enq_condition = 2'b01`.
  - Repeat with the broadcast in the same cycle as the dispatch accept → same result.
- Stage robids 0x10 and 0x12, then flush with `flush_robid = 0x11` → 0x12 is dropped, 0x10 is enqueued, `occupancy` = 0 after the handshake. Repeat with `flush_robid = 0x12` → both entries are kept.
- Wrap case: stage robid 0x41, flush with 0x3F → 0x41 is killed.
- Assert `reset_n` low while `occupancy = 2` → `enq_valid = 0` and `occupancy = 0` immediately; `disp_ready = 1`.

Source files
------------

// File: rtl/isq_enq_stage_pkg.sv
// isq_enq_stage_pkg: shared ISQ robid field location, robid type and wrap-aware age compare
package isq_enq_stage_pkg;
  localparam int ROB_SIZE_LOG = 6;
  localparam int ROBID_MSB = 247;
  localparam int ROBID_LSB = 241;
  typedef logic [ROB_SIZE_LOG:0] robid_t;
  function automatic logic rob_is_younger(robid_t rob, robid_t point);
    return point[ROB_SIZE_LOG] ^ rob[ROB_SIZE_LOG] ^ (point[ROB_SIZE_LOG-1:0] < rob[ROB_SIZE_LOG-1:0]);
  endfunction
endpackage

// File: rtl/isq_stage_entry.sv
// isq_stage_entry: one staging slot (write/clear/kill in; valid, data, live-merged condition, index out) snooping condition broadcasts
module isq_stage_entry
  import isq_enq_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 248,
  parameter int CONDITION_WIDTH = 2,
  parameter int INDEX_WIDTH = 4
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       write,
  input  logic                       clear,
  input  logic                       kill,
  input  logic [DATA_WIDTH-1:0]      write_data,
  input  logic [CONDITION_WIDTH-1:0] write_condition,
  input  logic [INDEX_WIDTH-1:0]     write_index,
  input  logic                       update_valid,
  input  robid_t                     update_robid,
  input  logic [CONDITION_WIDTH-1:0] update_mask,
  input  logic [CONDITION_WIDTH-1:0] update_in,
  output logic                       valid,
  output logic [DATA_WIDTH-1:0]      data,
  output logic [CONDITION_WIDTH-1:0] condition,
  output logic [INDEX_WIDTH-1:0]     index
);
  logic [CONDITION_WIDTH-1:0] cond_q;
  logic hit, write_hit;
  assign hit = update_valid & valid & (data[ROBID_MSB:ROBID_LSB] == update_robid);
  assign write_hit = update_valid & (write_data[ROBID_MSB:ROBID_LSB] == update_robid);
  assign condition = hit ? (cond_q & ~update_mask) | (update_in & update_mask) : cond_q;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 1'b0;
      data <= '0;
      cond_q <= '0;
      index <= '0;
    end else if (write) begin
      valid <= 1'b1;
      data <= write_data;
      cond_q <= write_hit ? (write_condition & ~update_mask) | (update_in & update_mask) : write_condition;
      index <= write_index;
    end else begin
      if (clear | kill) valid <= 1'b0;
      cond_q <= condition;
    end
  end
endmodule

// File: rtl/isq_enq_stage.sv
// isq_enq_stage: 2-entry dispatch-to-age-buffer staging FIFO (disp_* in, enq_* out, condition snoop, flush kill, occupancy)
module isq_enq_stage
  import isq_enq_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 248,
  parameter int CONDITION_WIDTH = 2,
  parameter int INDEX_WIDTH = 4
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       disp_valid,
  output logic                       disp_ready,
  input  logic [DATA_WIDTH-1:0]      disp_data,
  input  logic [CONDITION_WIDTH-1:0] disp_condition,
  input  logic [INDEX_WIDTH-1:0]     disp_index,
  output logic                       enq_valid,
  input  logic                       enq_ready,
  output logic [DATA_WIDTH-1:0]      enq_data,
  output logic [CONDITION_WIDTH-1:0] enq_condition,
  output logic [INDEX_WIDTH-1:0]     enq_index,
  input  logic                       update_condition_valid,
  input  logic [ROB_SIZE_LOG:0]      update_condition_robid,
  input  logic [CONDITION_WIDTH-1:0] update_condition_mask,
  input  logic [CONDITION_WIDTH-1:0] update_condition_in,
  input  logic                       flush_valid,
  input  logic [ROB_SIZE_LOG:0]      flush_robid,
  output logic [1:0]                 occupancy
);
  logic head_ptr, tail_ptr, head_next, accept, pop, head_kill;
  logic [1:0] count, count_next, e_valid, kill, keep, write, clear;
  logic [DATA_WIDTH-1:0] e_data [2];
  logic [CONDITION_WIDTH-1:0] e_cond [2];
  logic [INDEX_WIDTH-1:0] e_index [2];
  assign disp_ready = (count < 2'd2) & ~flush_valid;
  assign accept = disp_valid & disp_ready;
  assign head_kill = kill[head_ptr];
  assign enq_valid = e_valid[head_ptr] & ~head_kill;
  assign pop = enq_valid & enq_ready;
  assign enq_data = e_data[head_ptr];
  assign enq_condition = e_cond[head_ptr];
  assign enq_index = e_index[head_ptr];
  assign occupancy = count;
  for (genvar i = 0; i < 2; i++) begin : g_entry
    assign kill[i] = flush_valid & e_valid[i] & rob_is_younger(e_data[i][ROBID_MSB:ROBID_LSB], flush_robid);
    assign clear[i] = kill[i] | (pop & (head_ptr == 1'(i)));
    assign write[i] = accept & (tail_ptr == 1'(i));
    assign keep[i] = e_valid[i] & ~clear[i];
    isq_stage_entry #(
      .DATA_WIDTH(DATA_WIDTH),
      .CONDITION_WIDTH(CONDITION_WIDTH),
      .INDEX_WIDTH(INDEX_WIDTH)
    ) u_entry (
      .clock(clock),
      .reset_n(reset_n),
      .write(write[i]),
      .clear(clear[i]),
      .kill(kill[i]),
      .write_data(disp_data),
      .write_condition(disp_condition),
      .write_index(disp_index),
      .update_valid(update_condition_valid),
      .update_robid(update_condition_robid),
      .update_mask(update_condition_mask),
      .update_in(update_condition_in),
      .valid(e_valid[i]),
      .data(e_data[i]),
      .condition(e_cond[i]),
      .index(e_index[i])
    );
  end
  // Head follows the oldest survivor; a killed head with a surviving second entry hands over to it.
  assign count_next = 2'(keep[0]) + 2'(keep[1]) + 2'(accept);
  assign head_next = keep[head_ptr] ? head_ptr : keep[~head_ptr] ? ~head_ptr : accept ? tail_ptr : head_ptr;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_ptr <= 1'b0;
      tail_ptr <= 1'b0;
      count <= 2'd0;
    end else begin
      head_ptr <= head_next;
      tail_ptr <= head_next ^ count_next[0];
      count <= count_next;
    end
  end
endmodule

// File: tb/tb_isq_enq_stage.sv
// tb_isq_enq_stage: directed self-checking bench for isq_enq_stage
module tb_isq_enq_stage;
  logic clock = 1'b0, reset_n = 1'b0;
  logic disp_valid = 1'b0, disp_ready;
  logic [247:0] disp_data = '0;
  logic [1:0] disp_condition = '0;
  logic [3:0] disp_index = '0;
  logic enq_valid, enq_ready = 1'b1;
  logic [247:0] enq_data;
  logic [1:0] enq_condition;
  logic [3:0] enq_index;
  logic update_condition_valid = 1'b0;
  logic [6:0] update_condition_robid = '0;
  logic [1:0] update_condition_mask = '0, update_condition_in = '0;
  logic flush_valid = 1'b0;
  logic [6:0] flush_robid = '0;
  logic [1:0] occupancy;
  int total = 0, passed = 0;
  isq_enq_stage dut (
    .clock(clock), .reset_n(reset_n),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_data(disp_data),
    .disp_condition(disp_condition), .disp_index(disp_index),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_data(enq_data),
    .enq_condition(enq_condition), .enq_index(enq_index),
    .update_condition_valid(update_condition_valid), .update_condition_robid(update_condition_robid),
    .update_condition_mask(update_condition_mask), .update_condition_in(update_condition_in),
    .flush_valid(flush_valid), .flush_robid(flush_robid), .occupancy(occupancy)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic step;
    @(posedge clock);
    #1;
  endtask
  task automatic offer(input logic [6:0] r, input logic [1:0] c);
    disp_valid = 1'b1;
    disp_data = {r, 241'(r) ^ 241'h5a5a};
    disp_condition = c;
    disp_index = r[3:0];
  endtask
  task automatic upd(input logic [6:0] r, input logic [1:0] m, input logic [1:0] v);
    update_condition_valid = 1'b1;
    update_condition_robid = r;
    update_condition_mask = m;
    update_condition_in = v;
  endtask
  task automatic flush(input logic [6:0] r);
    flush_valid = 1'b1;
    flush_robid = r;
  endtask
  function automatic logic [63:0] rob_of(input logic [247:0] d);
    return 64'(d[247:241]);
  endfunction
  initial begin
    #12;
    check("rst_enq_valid", 64'(enq_valid), 64'd0);
    check("rst_occ", 64'(occupancy), 64'd0);
    check("rst_disp_ready", 64'(disp_ready), 64'd1);
    @(negedge clock);
    reset_n = 1'b1;
    offer(7'h05, 2'b00);
    step;
    check("pipe_v1", 64'(enq_valid), 64'd1);
    check("pipe_r1", rob_of(enq_data), 64'h05);
    check("pipe_o1", 64'(occupancy), 64'd1);
    check("pipe_data", 64'(enq_data[15:0]), 64'(16'h5a5a ^ 16'h05));
    check("pipe_idx", 64'(enq_index), 64'h5);
    offer(7'h06, 2'b00);
    step;
    check("pipe_r2", rob_of(enq_data), 64'h06);
    check("pipe_o2", 64'(occupancy), 64'd1);
    offer(7'h07, 2'b00);
    step;
    check("pipe_v3", 64'(enq_valid), 64'd1);
    check("pipe_r3", rob_of(enq_data), 64'h07);
    disp_valid = 1'b0;
    step;
    check("pipe_drain_occ", 64'(occupancy), 64'd0);
    check("pipe_drain_v", 64'(enq_valid), 64'd0);
    enq_ready = 1'b0;
    offer(7'h21, 2'b00);
    step;
    check("bp_o1", 64'(occupancy), 64'd1);
    offer(7'h22, 2'b00);
    check("bp_rdy1", 64'(disp_ready), 64'd1);
    step;
    check("bp_o2", 64'(occupancy), 64'd2);
    check("bp_rdy0", 64'(disp_ready), 64'd0);
    check("bp_head", rob_of(enq_data), 64'h21);
    offer(7'h23, 2'b00);
    step;
    check("bp_hold_occ", 64'(occupancy), 64'd2);
    check("bp_hold_head", rob_of(enq_data), 64'h21);
    enq_ready = 1'b1;
    step;
    check("bp_ord2", rob_of(enq_data), 64'h22);
    check("bp_ord2_occ", 64'(occupancy), 64'd1);
    step;
    check("bp_ord3", rob_of(enq_data), 64'h23);
    check("bp_ord3_occ", 64'(occupancy), 64'd1);
    disp_valid = 1'b0;
    step;
    check("bp_empty", 64'(occupancy), 64'd0);
    enq_ready = 1'b0;
    offer(7'h0A, 2'b00);
    step;
    disp_valid = 1'b0;
    check("cond_init", 64'(enq_condition), 64'd0);
    upd(7'h0A, 2'b01, 2'b01);
    #1;
    check("cond_comb", 64'(enq_condition), 64'b01);
    step;
    update_condition_valid = 1'b0;
    #1;
    check("cond_stored", 64'(enq_condition), 64'b01);
    upd(7'h0B, 2'b11, 2'b00);
    #1;
    check("cond_nomatch", 64'(enq_condition), 64'b01);
    upd(7'h0A, 2'b10, 2'b10);
    #1;
    check("cond_mask_hi", 64'(enq_condition), 64'b11);
    update_condition_valid = 1'b0;
    enq_ready = 1'b1;
    step;
    check("cond_pop", 64'(occupancy), 64'd0);
    enq_ready = 1'b0;
    offer(7'h0A, 2'b00);
    upd(7'h0A, 2'b01, 2'b01);
    step;
    disp_valid = 1'b0;
    update_condition_valid = 1'b0;
    #1;
    check("cond_same_cycle", 64'(enq_condition), 64'b01);
    enq_ready = 1'b1;
    step;
    enq_ready = 1'b0;
    offer(7'h10, 2'b00);
    step;
    offer(7'h12, 2'b00);
    step;
    disp_valid = 1'b0;
    check("fl_staged", 64'(occupancy), 64'd2);
    flush(7'h11);
    enq_ready = 1'b1;
    #1;
    check("fl_head_v", 64'(enq_valid), 64'd1);
    check("fl_head_r", rob_of(enq_data), 64'h10);
    check("fl_disp_rdy", 64'(disp_ready), 64'd0);
    step;
    flush_valid = 1'b0;
    check("fl_occ", 64'(occupancy), 64'd0);
    check("fl_v", 64'(enq_valid), 64'd0);
    enq_ready = 1'b0;
    offer(7'h10, 2'b00);
    step;
    offer(7'h12, 2'b00);
    step;
    disp_valid = 1'b0;
    flush(7'h12);
    step;
    flush_valid = 1'b0;
    check("fl_eq_occ", 64'(occupancy), 64'd2);
    check("fl_eq_head", rob_of(enq_data), 64'h10);
    enq_ready = 1'b1;
    step;
    check("fl_eq_second", rob_of(enq_data), 64'h12);
    step;
    check("fl_eq_empty", 64'(occupancy), 64'd0);
    enq_ready = 1'b0;
    offer(7'h41, 2'b00);
    step;
    disp_valid = 1'b0;
    flush(7'h3F);
    #1;
    check("wrap_kill_v", 64'(enq_valid), 64'd0);
    step;
    flush_valid = 1'b0;
    check("wrap_occ", 64'(occupancy), 64'd0);
    offer(7'h30, 2'b00);
    step;
    offer(7'h20, 2'b00);
    step;
    disp_valid = 1'b0;
    flush(7'h25);
    #1;
    check("hk_v", 64'(enq_valid), 64'd0);
    step;
    flush_valid = 1'b0;
    check("hk_occ", 64'(occupancy), 64'd1);
    check("hk_surv_v", 64'(enq_valid), 64'd1);
    check("hk_surv_r", rob_of(enq_data), 64'h20);
    enq_ready = 1'b1;
    step;
    check("hk_empty", 64'(occupancy), 64'd0);
    enq_ready = 1'b0;
    offer(7'h50, 2'b00);
    step;
    offer(7'h51, 2'b00);
    step;
    disp_valid = 1'b0;
    check("ar_full", 64'(occupancy), 64'd2);
    #2;
    reset_n = 1'b0;
    #1;
    check("ar_v", 64'(enq_valid), 64'd0);
    check("ar_occ", 64'(occupancy), 64'd0);
    check("ar_rdy", 64'(disp_ready), 64'd1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
